instruction_fetch_queue: RTL

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_pkg.sv | 18 +
 rtl/instruction_fetch_queue_fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared processor types for the instruction fetch queue: FSM states, queue entry layout
// and the default reset fetch address.
package instruction_fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } fetchState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Power-of-two deep FIFO of fetched {pc, instr} entries; flush wins over push and pop,
// and a push into a full queue is accepted only when a pop frees the slot on the same edge.
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetchEntry_t              pushEntry,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output fetchEntry_t              headEntry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetchEntry_t   mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign doPop     = pop && !empty;
    assign doPush    = push && (!full || doPop);
    assign headEntry = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: single-outstanding imem fetcher feeding a fetch_fifo.
// Optional feature macro: FETCH_PERF_COUNT_EN adds the perf_stall_cycles output.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = instruction_fetch_queue_pkg::DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetchState_t   state;
    fetchState_t   nextState;
    logic [31:0]   fetchPc;
    logic [31:0]   staleAddr;
    logic          postReset;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          lastSlot;
    logic          popFire;
    logic          pushFire;
    fetchEntry_t   pushEntry;
    fetchEntry_t   headEntry;
    logic          unusedRedirectLsbs;

    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    assign out_valid = !empty;
    assign out_pc    = headEntry.pc;
    assign out_instr = headEntry.instr;
    assign popFire   = out_valid && out_ready;
    assign lastSlot  = (count == CW'(DEPTH - 1));
    assign pushFire  = (state == REQ) && imem_ack && !redirect_valid;
    assign pushEntry = '{pc: fetchPc, instr: imem_rdata};

    // During FLUSH the abandoned request must stay visible unchanged until memory answers it.
    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == FLUSH) ? staleAddr : fetchPc;

    fetch_fifo #(.DEPTH(DEPTH)) fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pushFire),
        .pushEntry (pushEntry),
        .pop       (popFire),
        .flush     (redirect_valid),
        .full      (full),
        .empty     (empty),
        .headEntry (headEntry),
        .count     (count)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (redirect_valid)              nextState = REQ;
                else if (postReset && imem_ack)  nextState = FLUSH;
                else if (!full || popFire)       nextState = REQ;
            end
            REQ: begin
                if (redirect_valid)                         nextState = imem_ack ? REQ : FLUSH;
                else if (imem_ack && lastSlot && !popFire)  nextState = IDLE;
            end
            FLUSH: begin
                if (imem_ack) nextState = REQ;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetchPc   <= RESET_PC;
            staleAddr <= RESET_PC;
            postReset <= 1'b1;
        end else begin
            state     <= nextState;
            postReset <= 1'b0;
            if (redirect_valid)  fetchPc <= {redirect_pc[31:2], 2'b00};
            else if (pushFire)   fetchPc <= fetchPc + 32'd4;
            if (nextState == FLUSH && state != FLUSH) staleAddr <= fetchPc;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_stall_cycles <= '0;
        else if (out_ready && !out_valid && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif

endmodule
